// File: rtl/vga_fb_if.sv
// Frame-buffer read port and VGA output bundle between the scanout stage and its neighbours.
// The master side is the scanout engine; the slave side is the RAM plus the display sink.
interface vga_fb_if #(
    parameter int ADDR_W = 19
);
    logic              frame_ready;
    logic [7:0]        pixel_ram;
    logic [ADDR_W-1:0] addr_ram;
    logic              rd_en;
    logic [7:0]        vga_r;
    logic [7:0]        vga_g;
    logic [7:0]        vga_b;
    logic              hsync;
    logic              vsync;
    logic              blank_n;
    logic              frame_start;

    modport master (
        input  frame_ready,
        input  pixel_ram,
        output addr_ram,
        output rd_en,
        output vga_r,
        output vga_g,
        output vga_b,
        output hsync,
        output vsync,
        output blank_n,
        output frame_start
    );

    modport slave (
        output frame_ready,
        output pixel_ram,
        input  addr_ram,
        input  rd_en,
        input  vga_r,
        input  vga_g,
        input  vga_b,
        input  hsync,
        input  vsync,
        input  blank_n,
        input  frame_start
    );
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA scanout of a centred IMG_W x IMG_H grey image from frame-buffer RAM.
// Syncs, blanking and pixel data leave through one output register, aligned to the RAM latency.
module vga_fb_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int ADDR_W   = 19,
    parameter int RAM_LAT  = 1
) (
    input  logic      clk,
    input  logic      rst,
    vga_fb_if.master  bus
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int X0       = (H_ACTIVE - IMG_W) / 2;
    localparam int Y0       = (V_ACTIVE - IMG_H) / 2;
    localparam int HS_FIRST = H_ACTIVE + H_FP;
    localparam int HS_LAST  = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FP;
    localparam int VS_LAST  = V_ACTIVE + V_FP + V_SYNC - 1;

    typedef struct packed {
        logic hsync_n;
        logic vsync_n;
        logic blank_n;
        logic vis;
        logic fstart;
    } stage_t;

    localparam stage_t STAGE_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, blank_n: 1'b0,
                                      vis: 1'b0, fstart: 1'b0};

    logic [HW-1:0]     h_cnt_r;
    logic [VW-1:0]     v_cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              show_img_r;
    stage_t            pipe_r [RAM_LAT];

    logic [7:0]        rgb_r;
    logic              hsync_r;
    logic              vsync_r;
    logic              blank_n_r;
    logic              frame_start_r;

    logic              origin_s;
    logic              win_s;
    logic              show_cur_s;
    logic [ADDR_W-1:0] addr_cur_s;
    stage_t            head_s;
    stage_t            tail_s;

    // Decode the registered beam position into timing and window flags
    always_comb begin
        origin_s       = (h_cnt_r == HW'(0)) && (v_cnt_r == VW'(0));
        win_s          = (h_cnt_r >= HW'(X0)) && (h_cnt_r < HW'(X0 + IMG_W)) &&
                         (v_cnt_r >= VW'(Y0)) && (v_cnt_r < VW'(Y0 + IMG_H));
        // frame_ready is taken at the frame origin and reused for the rest of the frame
        show_cur_s     = origin_s ? bus.frame_ready : show_img_r;
        addr_cur_s     = origin_s ? ADDR_W'(0) : addr_r;
        head_s.hsync_n = !((h_cnt_r >= HW'(HS_FIRST)) && (h_cnt_r <= HW'(HS_LAST)));
        head_s.vsync_n = !((v_cnt_r >= VW'(VS_FIRST)) && (v_cnt_r <= VW'(VS_LAST)));
        head_s.blank_n = (h_cnt_r < HW'(H_ACTIVE)) && (v_cnt_r < VW'(V_ACTIVE));
        head_s.vis     = win_s && show_cur_s;
        head_s.fstart  = origin_s;
        tail_s         = pipe_r[RAM_LAT-1];
    end

    // Horizontal and vertical beam counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_r <= HW'(0);
            v_cnt_r <= VW'(0);
        end else if (h_cnt_r == HW'(H_TOTAL - 1)) begin
            h_cnt_r <= HW'(0);
            if (v_cnt_r == VW'(V_TOTAL - 1)) begin
                v_cnt_r <= VW'(0);
            end else begin
                v_cnt_r <= v_cnt_r + VW'(1);
            end
        end else begin
            h_cnt_r <= h_cnt_r + HW'(1);
        end
    end

    // Incremental read address and per-frame image enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r     <= ADDR_W'(0);
            show_img_r <= 1'b0;
        end else begin
            addr_r     <= addr_cur_s + ADDR_W'(win_s);
            show_img_r <= show_cur_s;
        end
    end

    // Delay line that matches the control flags to the RAM read latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RAM_LAT; i++) begin
                pipe_r[i] <= STAGE_IDLE;
            end
        end else begin
            pipe_r[0] <= head_s;
            for (int i = 1; i < RAM_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    // Output register: gate RAM data with the delayed visibility flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_r         <= 8'd0;
            hsync_r       <= 1'b1;
            vsync_r       <= 1'b1;
            blank_n_r     <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            rgb_r         <= tail_s.vis ? bus.pixel_ram : 8'd0;
            hsync_r       <= tail_s.hsync_n;
            vsync_r       <= tail_s.vsync_n;
            blank_n_r     <= tail_s.blank_n;
            frame_start_r <= tail_s.fstart;
        end
    end

    assign bus.addr_ram    = addr_cur_s;
    assign bus.rd_en       = win_s;
    assign bus.vga_r       = rgb_r;
    assign bus.vga_g       = rgb_r;
    assign bus.vga_b       = rgb_r;
    assign bus.hsync       = hsync_r;
    assign bus.vsync       = vsync_r;
    assign bus.blank_n     = blank_n_r;
    assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout using a reduced display geometry so several frames fit in a short run.
module tb_vga_fb_scanout #(
    parameter int RAM_LAT = 1
);
    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VA = 12, VFP = 2, VS = 2, VBP = 3;
    localparam int IW = 8,  IH = 6,  AW = 8;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int X0 = (HA - IW) / 2;
    localparam int Y0 = (VA - IH) / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   shown [64];
    logic [7:0] mem [256];
    logic [7:0] rd_q [RAM_LAT];

    always #5 clk = ~clk;

    vga_fb_if #(.ADDR_W(AW)) bus();

    vga_fb_scanout #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW), .RAM_LAT(RAM_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always_ff @(posedge clk) begin
        rd_q[0] <= mem[bus.addr_ram];
        for (int i = 1; i < RAM_LAT; i++) begin
            rd_q[i] <= rd_q[i-1];
        end
    end
    assign bus.pixel_ram = rd_q[RAM_LAT-1];

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: what the display should show for beam cycle j since reset release
    function automatic void model(input int j, output int hs, output int vs, output int bl,
                                  output int fs, output int rgb, output int addr, output int rd);
        int h, v, f, rows, cols;
        bit win, row_in;
        h      = j % HT;
        v      = (j / HT) % VT;
        f      = j / FRAME;
        row_in = (v >= Y0) && (v < Y0 + IH);
        win    = row_in && (h >= X0) && (h < X0 + IW);
        rows   = (v < Y0) ? 0 : ((v >= Y0 + IH) ? IH : v - Y0);
        cols   = !row_in ? 0 : ((h < X0) ? 0 : ((h >= X0 + IW) ? IW : h - X0));
        addr   = rows * IW + cols;
        rd     = win ? 1 : 0;
        hs     = (h >= HA + HFP && h < HA + HFP + HS) ? 0 : 1;
        vs     = (v >= VA + VFP && v < VA + VFP + VS) ? 0 : 1;
        bl     = (h < HA && v < VA) ? 1 : 0;
        fs     = (h == 0 && v == 0) ? 1 : 0;
        rgb    = (win && shown[f]) ? int'(mem[addr]) : 0;
    endfunction

    task automatic check_cycle(input int k);
        int hs, vs, bl, fs, rgb, addr, rd;
        model(k, hs, vs, bl, fs, rgb, addr, rd);
        chk("addr_ram", int'(bus.addr_ram), addr);
        chk("rd_en", int'(bus.rd_en), rd);
        if (k >= RAM_LAT + 1) begin
            model(k - RAM_LAT - 1, hs, vs, bl, fs, rgb, addr, rd);
        end else begin
            hs = 1; vs = 1; bl = 0; fs = 0; rgb = 0;
        end
        chk("vga_r", int'(bus.vga_r), rgb);
        chk("vga_g", int'(bus.vga_g), rgb);
        chk("vga_b", int'(bus.vga_b), rgb);
        chk("hsync", int'(bus.hsync), hs);
        chk("vsync", int'(bus.vsync), vs);
        chk("blank_n", int'(bus.blank_n), bl);
        chk("frame_start", int'(bus.frame_start), fs);
    endtask

    task automatic check_reset_state();
        chk("rst_vga_r", int'(bus.vga_r), 0);
        chk("rst_hsync", int'(bus.hsync), 1);
        chk("rst_vsync", int'(bus.vsync), 1);
        chk("rst_blank_n", int'(bus.blank_n), 0);
        chk("rst_frame_start", int'(bus.frame_start), 0);
        chk("rst_addr_ram", int'(bus.addr_ram), 0);
        chk("rst_rd_en", int'(bus.rd_en), 0);
    endtask

    // Called at a negedge with rst high; releases reset and follows the beam for n cycles
    task automatic run_segment(input int n);
        int hs_low, vs_low, bl_hi;
        hs_low = 0; vs_low = 0; bl_hi = 0;
        rst = 1'b0;
        #1;
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            check_cycle(k);
            if (k >= RAM_LAT + 1 && k < RAM_LAT + 1 + 2 * FRAME) begin
                hs_low += (bus.hsync == 1'b0) ? 1 : 0;
                vs_low += (bus.vsync == 1'b0) ? 1 : 0;
                bl_hi  += (bus.blank_n == 1'b1) ? 1 : 0;
                if (k == RAM_LAT + 2 * FRAME) begin
                    chk("hsync_low_2frames", hs_low, 2 * VT * HS);
                    chk("vsync_low_2frames", vs_low, 2 * VS * HT);
                    chk("blank_hi_2frames", bl_hi, 2 * VA * HA);
                end
            end
            if (k % FRAME == 0) begin
                bus.frame_ready = ($urandom_range(0, 2) != 0);
                shown[k / FRAME] = bus.frame_ready;
            end else if (k % FRAME == FRAME / 2 || $urandom_range(0, 149) == 0) begin
                bus.frame_ready = ~bus.frame_ready;
            end
        end
    endtask

    initial begin
        bus.frame_ready = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom_range(1, 255));
        end
        mem[1] = 8'd1;
        repeat (3) @(negedge clk);
        check_reset_state();

        run_segment(3 * FRAME + HT * 5 + 11);

        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state();
        repeat ($urandom_range(1, 5)) @(negedge clk);
        check_reset_state();

        run_segment(2 * FRAME + 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
